// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package sequential_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } div_state_e;

    function automatic logic is_busy_state(input div_state_e state);
        return (state != ST_IDLE);
    endfunction

endpackage : sequential_divider_pkg

// File: rtl/sequential_divider_divider_step.sv
// One radix-2 restoring division iteration: shift, trial subtract, select.
module divider_step
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic           borrow_s;

    // Because rem < divisor, shifted < 2*divisor: a borrow always shows up in bit WIDTH.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        borrow_s  = trial_s[WIDTH];
        if (borrow_s) begin
            rem_next = shifted_s[WIDTH-1:0];
        end else begin
            rem_next = trial_s[WIDTH-1:0];
        end
        quo_next = {quo[WIDTH-2:0], ~borrow_s};
    end

endmodule : divider_step

// File: rtl/sequential_divider.sv
// Unsigned multi-cycle divider: one quotient bit per clock, divide-by-zero flagged in one cycle.
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic             divisor_zero_s;
    logic             last_iter_s;

    assign divisor_zero_s = (divisor == {WIDTH{1'b0}});
    assign last_iter_s    = (cnt_r == LAST_ITER);

    // quo_r starts as the dividend and shifts quotient bits in as dividend bits shift out.
    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (divisor_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor_zero_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DIVIDE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DIVIDE;
                end
            end
            ST_DONE:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= is_busy_state(state_next_s);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= dividend;
                        divisor_r <= divisor;
                        dbz_r     <= divisor_zero_s;
                        if (divisor_zero_s) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                        end else begin
                            quotient_r  <= quotient_r;
                            remainder_r <= remainder_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DIVIDE: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (last_iter_s) begin
                        quotient_r  <= quo_step_s;
                        remainder_r <= rem_step_s;
                    end else begin
                        quotient_r  <= quotient_r;
                        remainder_r <= remainder_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule : sequential_divider

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand, quotient and remainder width in bits.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned numerator; captured on the start-accept edge.
REQ-006 divisor  input  WIDTH  unsigned denominator; captured on the start-accept edge.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quotient  output  WIDTH  unsigned quotient, registered.
REQ-010 remainder  output  WIDTH  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  set with done when the captured divisor was 0.

Function
REQ-012 FSM states: IDLE, DIVIDE, DONE; no other reachable states.
REQ-013 IDLE: start=1 captures the operands and clears the iteration counter; divisor≠0 -> DIVIDE, divisor=0 -> DONE.
REQ-014 DIVIDE: radix-2 restoring algorithm, one quotient bit per cycle, MSB first, exactly WIDTH cycles.
REQ-015 Each iteration: partial remainder shifted left by 1 with the next dividend bit.
REQ-016 Each iteration: a WIDTH+1-bit trial subtraction of the divisor.
REQ-017 Each iteration: if no borrow, keep the difference and shift in quotient bit 1; else restore and shift in 0.
REQ-018 After the WIDTH-th iteration -> DONE; DONE -> IDLE unconditionally on the next edge.
REQ-019 done=1 only in DONE; the divide latency is exactly WIDTH+1 cycles from the accept edge (33 for the default).
REQ-020 busy=1 in DIVIDE and DONE; busy=0 in IDLE.
REQ-021 The divide-by-zero latency is exactly 1 cycle from the accept edge.
REQ-022 Divide-by-zero results: quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-023 Normal results: div_by_zero=0, dividend = quotient*divisor + remainder, remainder < divisor.
REQ-024 quotient, remainder and div_by_zero hold their values from done until the next start is accepted.
REQ-025 start while busy=1 is ignored; captured operands and the operation in progress are unaffected.
REQ-026 Operand inputs may change freely after the accept edge without affecting the result.
REQ-027 start held high continuously: a new division is accepted on the first IDLE cycle after DONE.

Reset
REQ-028 rst_n=0 at a clock edge forces IDLE and clears busy, done, div_by_zero, quotient, remainder and the counter.
REQ-029 Reset mid-DIVIDE or in DONE aborts the operation; no done pulse is produced for the aborted division.
REQ-030 rst_n takes priority over start on the same edge.

Structure
REQ-031 A shared package holds the state encoding type and the default WIDTH constant.
REQ-032 A single sub-module, divider_step, holds the combinational shift, trial-subtract and select logic for one iteration.
REQ-033 The iteration counter is $clog2(WIDTH)+1 bits wide; no multipliers or dividers are inferred.

Verification
REQ-034 Basic: dividend=100, divisor=7, start -> done 33 cycles later, quotient=14, remainder=2, div_by_zero=0.
REQ-035 Extremes: 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-036 Small dividend: 3/10 -> quotient 0, remainder 3.
REQ-037 Zero divisor: 0x1234/0 -> done 1 cycle later, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1.
REQ-038 Busy start: 100/7 started, then start with 50/5 at cycle 10 -> ignored, result still 14 rem 2.
REQ-039 Reset mid-operation: rst_n=0 at cycle 16 -> all outputs 0, no done; a fresh 81/9 afterwards -> quotient 9, remainder 0.
REQ-040 Random: 10k random operand pairs checked against a reference model of REQ-023.
